dsp_rr_scheduler: RTL and testbench

DSP_RR_SCHEDULER -- requirements
Module: dsp_rr_scheduler

---
 rtl/dsp_rr_scheduler.sv | 138 +++++++++++++
 tb/tb_dsp_rr_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_rr_scheduler.sv
// Round-robin front end for one shared multiply/divide datapath.
// Two requesters compete for the datapath. A winner is accepted in IDLE,
// its operands are latched, the result is registered in EXEC and presented
// in RESP until the consumer takes it.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/ready/a/b/m        requester N operation (m=1 multiply, 0 divide)
//   rsp_valid/ready/id/out/dz     response handshake, owner, result, div-by-zero
//   busy                          block is not idle
//   op_count                      completed response handshakes (wrapping)
//
// state | meaning
// IDLE  | waiting for a valid requester; grant is combinational
// EXEC  | operands latched, result registered this cycle
// RESP  | result presented, waiting for rsp_ready
module dsp_rr_scheduler #(
   parameter int DATA_WIDTH = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req0_valid,
   output logic                      req0_ready,
   input  logic [DATA_WIDTH/2-1:0]   req0_a,
   input  logic [DATA_WIDTH/2-1:0]   req0_b,
   input  logic                      req0_m,
   input  logic                      req1_valid,
   output logic                      req1_ready,
   input  logic [DATA_WIDTH/2-1:0]   req1_a,
   input  logic [DATA_WIDTH/2-1:0]   req1_b,
   input  logic                      req1_m,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_id,
   output logic [DATA_WIDTH-1:0]     rsp_out,
   output logic                      rsp_dz,
   output logic                      busy,
   output logic [CNT_WIDTH-1:0]      op_count
);

   localparam int OW = DATA_WIDTH / 2;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t state, state_nx;

   logic           ptr;
   logic [OW-1:0]  op_a, op_b;
   logic           op_m, op_id;

   logic           gnt_any, gnt_id, accept;
   logic [DATA_WIDTH-1:0] dp_out;
   logic           dp_dz;

   // Grant: a lone valid requester wins; on contention the pointer decides.
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = ptr;
      if (req0_valid && req1_valid) begin
         gnt_any = 1'b1;
         gnt_id  = ptr;
      end else if (req0_valid) begin
         gnt_any = 1'b1;
         gnt_id  = 1'b0;
      end else if (req1_valid) begin
         gnt_any = 1'b1;
         gnt_id  = 1'b1;
      end
   end

   // Reset masks the readys so nothing is ever handshaken during reset.
   assign accept     = (state == IDLE) && gnt_any && !rst;
   assign req0_ready = accept && !gnt_id;
   assign req1_ready = accept && gnt_id;
   assign busy       = (state != IDLE);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = EXEC;
         EXEC:    state_nx = RESP;
         RESP:    if (rsp_valid && rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Shared datapath, fed only from the operand registers. A divide by zero
   // saturates to all-ones and raises the flag; multiplies never flag.
   always_comb begin
      dp_out = '0;
      dp_dz  = 1'b0;
      if (op_m) begin
         dp_out = DATA_WIDTH'(op_a) * DATA_WIDTH'(op_b);
      end else if (op_b == '0) begin
         dp_out = '1;
         dp_dz  = 1'b1;
      end else begin
         dp_out = DATA_WIDTH'(op_a / op_b);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         op_m      <= 1'b0;
         op_id     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_out   <= '0;
         rsp_dz    <= 1'b0;
         rsp_id    <= 1'b0;
         op_count  <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            ptr   <= ~gnt_id;
            op_a  <= gnt_id ? req1_a : req0_a;
            op_b  <= gnt_id ? req1_b : req0_b;
            op_m  <= gnt_id ? req1_m : req0_m;
            op_id <= gnt_id;
         end
         if (state == EXEC) begin
            rsp_out   <= dp_out;
            rsp_dz    <= dp_dz;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
         end
         if (state == RESP && rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dsp_rr_scheduler.sv
module tb_dsp_rr_scheduler;

   localparam int DW = 4;
   localparam int CW = 8;
   localparam int OW = DW / 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          req0_valid, req0_ready, req0_m;
   logic [OW-1:0] req0_a, req0_b;
   logic          req1_valid, req1_ready, req1_m;
   logic [OW-1:0] req1_a, req1_b;
   logic          rsp_valid, rsp_ready, rsp_id, rsp_dz, busy;
   logic [DW-1:0] rsp_out;
   logic [CW-1:0] op_count;

   dsp_rr_scheduler #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_m(req0_m),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_m(req1_m),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_out(rsp_out), .rsp_dz(rsp_dz), .busy(busy), .op_count(op_count)
   );

   int total = 0;
   int bad   = 0;

   // Reference: one outstanding operation at most, described by its age in
   // cycles since acceptance; the response is visible from age 1 onward.
   bit            m_pend;
   int            m_age;
   int            m_ptr;
   int            m_count;
   logic [DW-1:0] m_out;
   bit            m_dz;
   int            m_id;
   int            cyc;
   int            last_g;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] ref_result(input int a, input int b, input bit m);
      int r;
      if (m)           r = a * b;
      else if (b == 0) r = (1 << DW) - 1;
      else             r = a / b;
      return r[DW-1:0];
   endfunction

   task automatic set_req(input int n, input bit v, input int a, input int b, input bit m);
      if (n == 0) begin
         req0_valid = v; req0_a = OW'(a); req0_b = OW'(b); req0_m = m;
      end else begin
         req1_valid = v; req1_a = OW'(a); req1_b = OW'(b); req1_m = m;
      end
   endtask

   task automatic rand_ops();
      req0_a = OW'($urandom); req0_b = OW'($urandom); req0_m = 1'($urandom);
      req1_a = OW'($urandom); req1_b = OW'($urandom); req1_m = 1'($urandom);
   endtask

   // Entered and left at posedge+1 with inputs already driven.
   task automatic step();
      int g;
      int a, b;
      bit m;
      #1;
      g = -1;
      if (!m_pend && !rst) begin
         if (req0_valid && req1_valid) g = m_ptr;
         else if (req0_valid)          g = 0;
         else if (req1_valid)          g = 1;
      end
      check("req0_ready", 32'(req0_ready), 32'(g == 0));
      check("req1_ready", 32'(req1_ready), 32'(g == 1));
      check("busy", 32'(busy), 32'(m_pend));
      check("rsp_valid", 32'(rsp_valid), 32'(m_pend && m_age >= 1));
      if (m_pend && m_age >= 1) begin
         check("rsp_out", 32'(rsp_out), 32'(m_out));
         check("rsp_dz", 32'(rsp_dz), 32'(m_dz));
         check("rsp_id", 32'(rsp_id), 32'(m_id));
      end
      check("op_count", 32'(op_count), 32'(m_count));
      last_g = g;
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_pend = 0; m_ptr = 0; m_count = 0;
      end else if (g >= 0) begin
         a = (g == 1) ? int'(req1_a) : int'(req0_a);
         b = (g == 1) ? int'(req1_b) : int'(req0_b);
         m = (g == 1) ? req1_m : req0_m;
         m_pend = 1; m_age = 0; m_ptr = 1 - g; m_id = g;
         m_out = ref_result(a, b, m);
         m_dz  = !m && (b == 0);
      end else if (m_pend) begin
         if (m_age == 0) m_age = 1;
         else if (rsp_ready) begin
            m_pend  = 0;
            m_count = (m_count + 1) % (1 << CW);
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int exp_alt, prev_cyc, guard;
      rst = 1'b1; rsp_ready = 1'b1;
      set_req(0, 1, 1, 1, 1);
      set_req(1, 1, 1, 1, 1);
      repeat (2) @(posedge clk);
      #1;
      m_pend = 0; m_age = 0; m_ptr = 0; m_count = 0; cyc = 0; last_g = -1;
      m_out = '0; m_dz = 0; m_id = 0;

      // reset state, readys masked while rst is high
      check("rst_out", 32'(rsp_out), 0);
      check("rst_dz", 32'(rsp_dz), 0);
      check("rst_id", 32'(rsp_id), 0);
      check("rst_valid", 32'(rsp_valid), 0);
      check("rst_count", 32'(op_count), 0);
      step();
      rst = 1'b0;

      // single multiply 3*3 from requester 0
      set_req(1, 0, 0, 0, 0);
      set_req(0, 1, 3, 3, 1);
      step();
      check("t1_grant", 32'(last_g), 0);
      set_req(0, 0, 0, 0, 0);
      step();
      check("t1_valid", 32'(rsp_valid), 1);
      check("t1_out", 32'(rsp_out), 9);
      check("t1_id", 32'(rsp_id), 0);
      check("t1_dz", 32'(rsp_dz), 0);
      step();
      step();
      check("t1_count", 32'(op_count), 1);

      // continuous contention from reset: alternating grants every 3 cycles
      do_reset();
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      exp_alt = 0; prev_cyc = -1;
      for (int i = 0; i < 13; i++) begin
         rand_ops();
         step();
         if (last_g >= 0) begin
            check("rr_alt", 32'(last_g), 32'(exp_alt));
            if (prev_cyc >= 0) check("rr_gap", 32'(cyc - prev_cyc), 3);
            exp_alt  = 1 - exp_alt;
            prev_cyc = cyc;
         end
      end

      // divide by zero, then a normal divide, on requester 1
      req0_valid = 1'b0; req1_valid = 1'b0;
      while (m_pend) step();
      set_req(1, 1, 2, 0, 0);
      step();
      set_req(1, 0, 0, 0, 0);
      step();
      check("dz_out", 32'(rsp_out), 32'hF);
      check("dz_flag", 32'(rsp_dz), 1);
      check("dz_id", 32'(rsp_id), 1);
      step();
      set_req(1, 1, 3, 2, 0);
      step();
      set_req(1, 0, 0, 0, 0);
      step();
      check("div_out", 32'(rsp_out), 1);
      check("div_dz", 32'(rsp_dz), 0);
      step();

      // backpressure: response held five cycles while both requesters wait
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_noready", 32'(last_g), 32'(-1));
         check("bp_busy", 32'(busy), 1);
      end
      rsp_ready = 1'b1;
      step();
      check("bp_noaccept", 32'(last_g), 32'(-1));
      step();
      check("bp_accept", 32'(last_g >= 0), 1);

      // reset during EXEC discards the operation and re-favours requester 0
      while (m_pend) begin
         req0_valid = 1'b0; req1_valid = 1'b0;
         step();
      end
      do_reset();
      set_req(0, 1, 1, 2, 1);
      set_req(1, 0, 0, 0, 0);
      step();
      check("ex_grant0", 32'(last_g), 0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("ex_busy", 32'(busy), 0);
      check("ex_valid", 32'(rsp_valid), 0);
      check("ex_count", 32'(op_count), 0);
      step();
      check("ex_ptr", 32'(last_g), 0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst        = ($urandom_range(0, 49) == 0);
         req0_valid = 1'($urandom);
         req1_valid = 1'($urandom);
         rsp_ready  = ($urandom_range(0, 3) != 0);
         rand_ops();
         step();
      end

      // counter wrap
      rst = 1'b0; rsp_ready = 1'b1; req1_valid = 1'b0;
      guard = 0;
      while (m_count != 255 && guard < 2000) begin
         req0_valid = 1'b1;
         rand_ops();
         step();
         guard++;
      end
      check("wrap_255", 32'(op_count), 255);
      req0_valid = 1'b1;
      step();
      req0_valid = 1'b0;
      step();
      step();
      check("wrap_0", 32'(op_count), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
